fw_path_sequencer: RTL and testbench

//  Control FSM that runs the Floyd-Warshall all-pairs kernel in place on an N x N path matrix.
//  The matrix is held in an external memref array (row-major, addr = i*N + j).
//  The block drives one registered read port (1-cycle latency) and one write port.
//  It replaces the HLS/MLIR kernel in the floyd_warshall testbenches and is compared against them.

---
 rtl/fw_pkg.sv | 30 +++
 rtl/fw_loop_counter.sv | 45 ++++
 rtl/fw_path_sequencer.sv | 127 ++++++++++++
 tb/tb_fw_path_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_pkg.sv
// Shared state encoding and index helpers for the Floyd-Warshall path sequencer.
package fw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_IK,
    RD_KJ,
    RD_IJ,
    WB,
    DONE
  } fw_state_e;

  // Degenerate sizes (N=1) still need at least one bit of counter/address.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int calc_addr_w(input int n);
    return clog2_min1(n * n);
  endfunction

  function automatic int calc_idx_w(input int n);
    return clog2_min1(n);
  endfunction

  function automatic int idx2addr(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/fw_loop_counter.sv
// Three-level nested (k outer, i middle, j inner) loop counter, each 0..N-1.
module fw_loop_counter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             clear,
  output logic [IDX_W-1:0] k,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);

  assign last = (k == MAX_IDX) && (i == MAX_IDX) && (j == MAX_IDX);

  // Each level wraps at N-1 rather than at the power of two, so non-power-of-two N works.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
      i <= '0;
      j <= '0;
    end else if (clear) begin
      k <= '0;
      i <= '0;
      j <= '0;
    end else if (advance) begin
      if (j == MAX_IDX) begin
        j <= '0;
        if (i == MAX_IDX) begin
          i <= '0;
          k <= (k == MAX_IDX) ? '0 : k + 1'b1;
        end else begin
          i <= i + 1'b1;
        end
      end else begin
        j <= j + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fw_path_sequencer.sv
// Runs the Floyd-Warshall kernel in place on an external N x N row-major matrix,
// four cycles per (k,i,j): three reads then a conditional write-back.
module fw_path_sequencer
  import fw_pkg::*;
#(
  parameter int N      = 8,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = calc_addr_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  localparam int IDX_W = calc_idx_w(N);

  fw_state_e        state;
  logic [WIDTH-1:0] ik_q;
  logic [WIDTH-1:0] kj_q;
  logic [WIDTH-1:0] sum;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] j;
  logic             last;
  logic             clear;
  logic             advance;
  logic             take_wr;
  logic [ADDR_W-1:0] addr_ik;
  logic [ADDR_W-1:0] addr_kj;
  logic [ADDR_W-1:0] addr_ij;

  fw_loop_counter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_loop (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .clear   (clear),
    .k       (k),
    .i       (i),
    .j       (j),
    .last    (last)
  );

  assign clear   = (state == IDLE) && start;
  assign advance = (state == WB);

  assign addr_ik = ADDR_W'(idx2addr(int'(i), int'(k), N));
  assign addr_kj = ADDR_W'(idx2addr(int'(k), int'(j), N));
  assign addr_ij = ADDR_W'(idx2addr(int'(i), int'(j), N));

  // In WB, rd_data carries path[i][j]; the sum wraps and the compare is signed.
  assign sum     = ik_q + kj_q;
  assign take_wr = $signed(sum) < $signed(rd_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ik_q  <= '0;
      kj_q  <= '0;
    end else begin
      case (state)
        IDLE:    if (start) state <= RD_IK;
        RD_IK:   state <= RD_KJ;
        RD_KJ: begin
          ik_q  <= rd_data;
          state <= RD_IJ;
        end
        RD_IJ: begin
          kj_q  <= rd_data;
          state <= WB;
        end
        WB:      state <= last ? DONE : RD_IK;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state and counters, so rd_* never depends on rd_data.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      RD_IK: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = addr_ik;
      end
      RD_KJ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = addr_kj;
      end
      RD_IJ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = addr_ij;
      end
      WB: begin
        busy = 1'b1;
        if (take_wr) begin
          wr_en   = 1'b1;
          wr_addr = addr_ij;
          wr_data = sum;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fw_path_sequencer.sv
// Directed bench for fw_path_sequencer: an N=3 and an N=8 instance share one memory model.
module tb_fw_path_sequencer;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        load;
  logic        rec_clear;
  logic        start3;
  logic        start8;
  logic [31:0] rd_q;
  logic [31:0] mem       [64];
  logic [31:0] img       [64];
  logic [31:0] model_mem [64];
  logic [31:0] img3      [9];
  logic [31:0] exp3      [9];
  longint unsigned model_sig;
  int vectors;
  int miscompares;

  logic        busy3, done3, rd_en3, wr_en3;
  logic [3:0]  rd_addr3, wr_addr3;
  logic [31:0] wr_data3;
  logic        busy8, done8, rd_en8, wr_en8;
  logic [5:0]  rd_addr8, wr_addr8;
  logic [31:0] wr_data8;

  fw_path_sequencer #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_q),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3)
  );

  fw_path_sequencer #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_q),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_busy, m_done, m_re, m_we;
  logic [5:0]  m_ra, m_wa;
  logic [31:0] m_wd;
  assign m_busy = sel ? busy8 : busy3;
  assign m_done = sel ? done8 : done3;
  assign m_re   = sel ? rd_en8 : rd_en3;
  assign m_we   = sel ? wr_en8 : wr_en3;
  assign m_ra   = sel ? rd_addr8 : {2'b00, rd_addr3};
  assign m_wa   = sel ? wr_addr8 : {2'b00, wr_addr3};
  assign m_wd   = sel ? wr_data8 : wr_data3;

  // Trace hash entry: read address only when reading, write address/data only when writing.
  function automatic longint unsigned mix(input longint unsigned s, input logic re, input int ra,
                                          input logic we, input int wa, input logic [31:0] wd);
    logic [63:0] e;
    e = {14'd0, re, re ? ra[7:0] : 8'd0, we, we ? wa[7:0] : 8'd0, we ? wd : 32'd0};
    return (s * 64'd1099511628211) ^ e;
  endfunction

  // Memory with one-cycle registered read, shared by whichever DUT is selected.
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 64; a++) mem[a] <= img[a];
    end else begin
      if (m_we) mem[m_wa] <= m_wd;
      if (m_re) rd_q <= mem[m_ra];
    end
  end

  int              cyc, busy_n, done_n, wr_n, overlap_n, first_busy, done_at, first_rd_addr;
  longint unsigned rec_sig;
  logic [5:0]      wlog_a [8];
  logic [31:0]     wlog_d [8];

  always @(negedge clk) begin
    if (rec_clear) begin
      cyc <= 0; busy_n <= 0; done_n <= 0; wr_n <= 0; overlap_n <= 0;
      first_busy <= -1; done_at <= -1; first_rd_addr <= -1; rec_sig <= 64'd0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        busy_n <= busy_n + 1;
        if (first_busy < 0) begin
          first_busy    <= cyc;
          first_rd_addr <= int'(m_ra);
        end
        rec_sig <= mix(rec_sig, m_re, int'(m_ra), m_we, int'(m_wa), m_wd);
      end
      if (m_done) begin
        done_n  <= done_n + 1;
        done_at <= cyc;
      end
      if (m_we) begin
        if (wr_n < 8) begin
          wlog_a[wr_n[2:0]] <= m_wa;
          wlog_d[wr_n[2:0]] <= m_wd;
        end
        wr_n <= wr_n + 1;
      end
      if (m_re && m_we) overlap_n <= overlap_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sequential reference: same read/write order and per-cycle trace as the kernel.
  task automatic model_run(input int n);
    logic [31:0] s;
    model_sig = 64'd0;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          model_sig = mix(model_sig, 1'b1, i * n + k, 1'b0, 0, 32'd0);
          model_sig = mix(model_sig, 1'b1, k * n + j, 1'b0, 0, 32'd0);
          model_sig = mix(model_sig, 1'b1, i * n + j, 1'b0, 0, 32'd0);
          s = model_mem[i * n + k] + model_mem[k * n + j];
          if ($signed(s) < $signed(model_mem[i * n + j])) begin
            model_mem[i * n + j] = s;
            model_sig = mix(model_sig, 1'b0, 0, 1'b1, i * n + j, s);
          end else begin
            model_sig = mix(model_sig, 1'b0, 0, 1'b0, 0, 32'd0);
          end
        end
  endtask

  task automatic prep3();
    for (int a = 0; a < 64; a++) img[a] = (a < 9) ? img3[a] : 32'd0;
    model_mem = img;
    model_run(3);
  endtask

  task automatic applyStimulus(input logic use8, input logic do_load);
    sel       = use8;
    load      = do_load;
    rec_clear = 1'b1;
    tick();
    load      = 1'b0;
    rec_clear = 1'b0;
    if (use8) start8 = 1'b1;
    else      start3 = 1'b1;
    tick();
    start3 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_done(input string pfx, input int n);
    int limit;
    int c;
    limit = 4 * n * n * n + 16;
    c = 0;
    while (done_n == 0 && c < limit) begin
      tick();
      c++;
    end
    checkOutput({pfx, ".no_timeout"}, longint'(c < limit), 64'd1);
    repeat (3) tick();
  endtask

  task automatic checkRun(input string pfx, input int n);
    int work;
    work = 4 * n * n * n;
    checkOutput({pfx, ".done_latency"}, longint'(done_at - first_busy), longint'(work));
    checkOutput({pfx, ".busy_cycles"}, longint'(busy_n), longint'(work));
    checkOutput({pfx, ".done_pulses"}, longint'(done_n), 64'd1);
    checkOutput({pfx, ".first_rd_addr"}, longint'(first_rd_addr), 64'd0);
    checkOutput({pfx, ".rd_wr_overlap"}, longint'(overlap_n), 64'd0);
    checkOutput({pfx, ".trace"}, longint'(rec_sig), longint'(model_sig));
  endtask

  task automatic check_mem3(input string pfx);
    for (int a = 0; a < 9; a++)
      checkOutput($sformatf("%s.mem%0d", pfx, a), longint'(mem[a]), longint'(exp3[a]));
  endtask

  task automatic check_write(input string pfx, input int idx, input int addr, input logic [31:0] data);
    checkOutput($sformatf("%s.wr%0d_addr", pfx, idx), longint'(wlog_a[idx]), longint'(addr));
    checkOutput($sformatf("%s.wr%0d_data", pfx, idx), longint'(wlog_d[idx]), longint'(data));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; sel = 1'b0; load = 1'b0; rec_clear = 1'b0; start3 = 1'b0; start8 = 1'b0;
    for (int a = 0; a < 64; a++) img[a] = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.n3_outputs",
                longint'({busy3, done3, rd_en3, wr_en3, rd_addr3, wr_addr3, wr_data3}), 64'd0);
    checkOutput("reset.n8_outputs",
                longint'({busy8, done8, rd_en8, wr_en8, rd_addr8, wr_addr8, wr_data8}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Small graph: three improvements, in a fixed order.
    img3 = '{32'd0, 32'd1, 32'd9, 32'd9, 32'd0, 32'd1, 32'd1, 32'd9, 32'd0};
    exp3 = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd0, 32'd1, 32'd1, 32'd2, 32'd0};
    prep3();
    applyStimulus(1'b0, 1'b1);
    wait_done("s1", 3);
    checkRun("s1", 3);
    checkOutput("s1.write_count", longint'(wr_n), 64'd3);
    check_write("s1", 0, 7, 32'd2);
    check_write("s1", 1, 2, 32'd2);
    check_write("s1", 2, 3, 32'd2);
    check_mem3("s1");

    // Full-size run against the sequential reference.
    for (int a = 0; a < 64; a++) img[a] = (a == 32) ? 32'd0 : 32'(a + 1);
    model_mem = img;
    model_run(8);
    applyStimulus(1'b1, 1'b1);
    wait_done("s2", 8);
    checkRun("s2", 8);
    for (int a = 0; a < 64; a++)
      checkOutput($sformatf("s2.mem%0d", a), longint'(mem[a]), longint'(model_mem[a]));

    // Ties everywhere: equal sums never write.
    for (int a = 0; a < 9; a++) img3[a] = 32'd5;
    exp3 = img3;
    prep3();
    applyStimulus(1'b0, 1'b1);
    wait_done("s3", 3);
    checkRun("s3", 3);
    checkOutput("s3.write_count", longint'(wr_n), 64'd0);
    check_mem3("s3");

    // MAX at [0][1]: column 0 zeros pull [1][2] to 0 first, then [0][1] drops to 0.
    img3 = '{32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 9; a++) exp3[a] = 32'd0;
    prep3();
    applyStimulus(1'b0, 1'b1);
    wait_done("s4a", 3);
    checkRun("s4a", 3);
    checkOutput("s4a.write_count", longint'(wr_n), 64'd2);
    check_write("s4a", 0, 5, 32'd0);
    check_write("s4a", 1, 1, 32'd0);
    check_mem3("s4a");

    // MAX+1 wraps negative and must win a signed compare.
    img3 = '{32'd0, 32'h7FFF_FFFF, 32'd9, 32'd0, 32'd0, 32'd1, 32'd0, 32'd9, 32'd0};
    exp3 = '{32'h8000_0000, 32'h8000_0009, 32'h8000_0000, 32'd0, 32'd0, 32'd1, 32'd0, 32'd9, 32'd0};
    prep3();
    applyStimulus(1'b0, 1'b1);
    wait_done("s4b", 3);
    checkRun("s4b", 3);
    checkOutput("s4b.write_count", longint'(wr_n), 64'd3);
    check_write("s4b", 0, 2, 32'h8000_0000);
    check_write("s4b", 1, 0, 32'h8000_0000);
    check_write("s4b", 2, 1, 32'h8000_0009);
    check_mem3("s4b");

    // Start pulses while busy are ignored.
    img3 = '{32'd0, 32'd1, 32'd9, 32'd9, 32'd0, 32'd1, 32'd1, 32'd9, 32'd0};
    exp3 = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd0, 32'd1, 32'd1, 32'd2, 32'd0};
    prep3();
    applyStimulus(1'b0, 1'b1);
    repeat (9) tick();
    start3 = 1'b1; tick(); start3 = 1'b0;
    repeat (39) tick();
    start3 = 1'b1; tick(); start3 = 1'b0;
    wait_done("s5", 3);
    repeat (10) tick();
    checkRun("s5", 3);
    check_mem3("s5");

    // Reset mid-run after the first write, then rerun on the partially updated matrix.
    prep3();
    applyStimulus(1'b0, 1'b1);
    repeat (39) tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s6.reset_outputs",
                longint'({busy3, done3, rd_en3, wr_en3, rd_addr3, wr_addr3, wr_data3}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    img3 = '{32'd0, 32'd1, 32'd9, 32'd9, 32'd0, 32'd1, 32'd1, 32'd2, 32'd0};
    checkOutput("s6.partial_mem7", longint'(mem[7]), 64'd2);
    checkOutput("s6.partial_mem2", longint'(mem[2]), 64'd9);
    prep3();
    applyStimulus(1'b0, 1'b0);
    wait_done("s6", 3);
    checkRun("s6", 3);
    check_mem3("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
